// File: rtl/mcs_io_pkg.sv
// Shared definitions for MCS I/O bus responders: register offsets, STATUS layout
// and the receiver FSM state encoding.
package mcs_io_pkg;

    localparam logic [1:0] RXDATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;

    localparam int ST_VALID     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] pack_status(
        input logic                  valid,
        input logic                  full,
        input logic                  overrun,
        input logic                  frame_err,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [31:0] s;
        s                                = '0;
        s[ST_VALID]                      = valid;
        s[ST_FULL]                       = full;
        s[ST_OVERRUN]                    = overrun;
        s[ST_FRAME_ERR]                  = frame_err;
        s[ST_COUNT_LSB +: ST_COUNT_W]    = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through head. A push while
// full is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mcs_uart_rx.sv
// UART receiver with a byte FIFO, read by firmware over the MicroBlaze MCS I/O
// bus. Holds the input synchronizer, the frame FSM, bus decode and sticky flags.
module mcs_uart_rx
    import mcs_io_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hC000_0010
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXD,
    input  logic [31:0] IO_Address,
    input  logic        IO_Addr_Strobe,
    input  logic        IO_Read_Strobe,
    input  logic        IO_Write_Strobe,
    input  logic [3:0]  IO_Byte_Enable,
    input  logic [31:0] IO_Write_Data,
    output logic [31:0] IO_Read_Data,
    output logic        IO_Ready,
    output logic        RX_IRQ
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2);

    logic             rxd_s1_q, rxd_s2_q, rxd_edge_q;
    logic             line, fall;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req, frame_set, stop_sample;

    logic             ready_q, rd_q;
    logic [1:0]       ofs_q;
    logic [1:0]       clr_q;
    logic [31:0]      status_q;
    logic             ovr_q, ferr_q;
    logic             sel, pop_req, ovr_set;

    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             unused_bits;

    // Synchronizer and edge register idle high so reset never fakes a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_edge_q <= 1'b1;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_edge_q <= rxd_s2_q;
        end
    end

    assign line = rxd_s2_q;
    assign fall = rxd_edge_q & ~rxd_s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (state_q == RX_STOP) && (cnt_q == CNT_LAST);
        push_req    = stop_sample & line;
        frame_set   = stop_sample & ~line;
    end

    assign sel     = IO_Addr_Strobe & (IO_Address[31:4] == BASE_ADDR[31:4]);
    assign pop_req = ready_q & rd_q & (ofs_q == RXDATA_OFS);
    assign ovr_set = push_req & fifo_full & ~pop_req;

    // STATUS is snapshotted in the request cycle; RXDATA is taken live in the ack cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_q  <= 1'b0;
            rd_q     <= 1'b0;
            ofs_q    <= '0;
            clr_q    <= '0;
            status_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            ready_q  <= sel;
            rd_q     <= sel & IO_Read_Strobe;
            ofs_q    <= IO_Address[3:2];
            clr_q    <= (sel && IO_Write_Strobe && IO_Byte_Enable[0] &&
                         IO_Address[3:2] == STATUS_OFS) ? IO_Write_Data[3:2] : 2'b00;
            status_q <= pack_status(~fifo_empty, fifo_full, ovr_q, ferr_q,
                                    ST_COUNT_W'(fifo_count));
            ovr_q    <= (ovr_q & ~clr_q[0]) | ovr_set;
            ferr_q   <= (ferr_q & ~clr_q[1]) | frame_set;
        end
    end

    always_comb begin
        IO_Read_Data = '0;
        if (ready_q && rd_q) begin
            case (ofs_q)
                RXDATA_OFS: IO_Read_Data = {24'b0, fifo_empty ? 8'h00 : fifo_dout};
                STATUS_OFS: IO_Read_Data = status_q;
                default:    IO_Read_Data = '0;
            endcase
        end
    end

    assign IO_Ready = ready_q;
    assign RX_IRQ   = ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i (CLK),
        .rst_i (RST),
        .push  (push_req),
        .pop   (pop_req),
        .din   (shift_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign unused_bits = ^{IO_Address[1:0], IO_Write_Data[31:4], IO_Write_Data[1:0],
                           IO_Byte_Enable[3:1]};

endmodule

// File: tb/tb_mcs_uart_rx.sv
// Bench for mcs_uart_rx at 10 clocks per bit: a queue-based model of the FIFO and
// flags predicts every bus response; one negedge process checks the bus each cycle.
module tb_mcs_uart_rx;
    localparam int          CLK_HZ  = 1_000_000;
    localparam int          BAUD    = 100_000;
    localparam int          DEPTH   = 16;
    localparam int          BIT_CYC = 10;
    localparam logic [31:0] BASE    = 32'hC000_0010;
    localparam logic [31:0] A_RXDATA = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_RSV8   = BASE + 32'h8;
    localparam logic [31:0] A_OUT    = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [31:0] io_addr = '0;
    logic        io_as = 1'b0, io_rs = 1'b0, io_ws = 1'b0;
    logic [3:0]  io_be = '0;
    logic [31:0] io_wd = '0;
    logic [31:0] io_rd;
    logic        io_ready;
    logic        rx_irq;

    mcs_uart_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .CLK(clk), .RST(rst), .RXD(rxd),
        .IO_Address(io_addr), .IO_Addr_Strobe(io_as), .IO_Read_Strobe(io_rs),
        .IO_Write_Strobe(io_ws), .IO_Byte_Enable(io_be), .IO_Write_Data(io_wd),
        .IO_Read_Data(io_rd), .IO_Ready(io_ready), .RX_IRQ(rx_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          checking = 1'b0;
    logic [7:0]  m_q[$];
    bit          m_ovr  = 1'b0;
    bit          m_ferr = 1'b0;
    int          due_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [31:0] model_status();
        int n = m_q.size();
        return (32'(n) << 8) | (32'(m_ferr) << 3) | (32'(m_ovr) << 2) |
               (32'(n == DEPTH) << 1) | 32'(n != 0);
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check("ack_ready", 32'(io_ready), 32'd1);
                check("ack_data", io_rd, exp_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else begin
                check("idle_ready", 32'(io_ready), 32'd0);
                check("idle_data", io_rd, 32'd0);
            end
        end
    end

    task automatic bus(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                       input logic [3:0] be, input bit use_lit, input logic [31:0] lit);
        logic [31:0] e;
        bit          hit;
        @(posedge clk); #1;
        io_addr = addr; io_as = 1'b1; io_rs = !wr; io_ws = wr; io_wd = wd; io_be = be;
        hit = (addr[31:4] == BASE[31:4]);
        e   = '0;
        if (hit) begin
            if (!wr) begin
                if (addr[3:2] == 2'd0) begin
                    if (m_q.size() > 0) e = {24'd0, m_q.pop_front()};
                end else if (addr[3:2] == 2'd1) begin
                    e = model_status();
                end
            end else if (addr[3:2] == 2'd1 && be[0]) begin
                if (wd[2]) m_ovr = 1'b0;
                if (wd[3]) m_ferr = 1'b0;
            end
            if (use_lit) e = lit;
            due_q.push_back(cyc + 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        io_as = 1'b0; io_rs = 1'b0; io_ws = 1'b0;
    endtask

    task automatic rd_m(input logic [31:0] addr);
        bus(addr, 1'b0, 32'd0, 4'h0, 1'b0, 32'd0);
    endtask

    task automatic rd_l(input logic [31:0] addr, input logic [31:0] lit);
        bus(addr, 1'b0, 32'd0, 4'h0, 1'b1, lit);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
        bus(addr, 1'b1, data, 4'h1, 1'b0, 32'd0);
    endtask

    // Two selected reads in consecutive cycles; a STATUS follow-up sees the pre-pop state.
    task automatic b2b(input bit second_status);
        logic [31:0] e0, e1, st;
        @(posedge clk); #1;
        st = model_status();
        e0 = (m_q.size() > 0) ? {24'd0, m_q.pop_front()} : 32'd0;
        if (second_status) e1 = st;
        else e1 = (m_q.size() > 0) ? {24'd0, m_q.pop_front()} : 32'd0;
        io_addr = A_RXDATA; io_as = 1'b1; io_rs = 1'b1; io_ws = 1'b0;
        due_q.push_back(cyc + 1); exp_q.push_back(e0);
        @(posedge clk); #1;
        io_addr = second_status ? A_STATUS : A_RXDATA;
        due_q.push_back(cyc + 1); exp_q.push_back(e1);
        @(posedge clk); #1;
        io_as = 1'b0; io_rs = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        @(posedge clk); #1;
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(posedge clk); #1;
            rxd = b[i];
        end
        repeat (BIT_CYC) @(posedge clk); #1;
        rxd = stop;
        repeat (BIT_CYC) @(posedge clk); #1;
        rxd = 1'b1;
        if (stop) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_irq(input string name);
        @(posedge clk); #1;
        check(name, 32'(rx_irq), 32'(m_q.size() != 0));
    endtask

    initial begin
        int nrd;
        repeat (1) @(posedge clk); #1;
        checking = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        check("reset_irq", 32'(rx_irq), 32'd0);
        rd_l(A_STATUS, 32'h0000_0000);

        // single byte with push timing
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (98) @(posedge clk);
                @(negedge clk);
                check("irq_before_stop", 32'(rx_irq), 32'd0);
                @(negedge clk);
                check("irq_after_stop", 32'(rx_irq), 32'd1);
            end
        join
        rd_l(A_STATUS, 32'h0000_0101);
        rd_l(A_RXDATA, 32'h0000_00A5);
        chk_irq("irq_after_pop");
        rd_l(A_STATUS, 32'h0000_0000);

        // overrun
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        rd_l(A_STATUS, 32'h0000_1007);
        for (int i = 0; i < 16; i++) rd_m(A_RXDATA);
        wr_reg(A_STATUS, 32'h4);
        rd_l(A_STATUS, 32'h0000_0000);

        // frame error and W1C
        send_frame(8'h3C, 1'b0);
        rd_l(A_STATUS, 32'h0000_0008);
        chk_irq("irq_frame_err");
        wr_reg(A_STATUS, 32'h8);
        rd_l(A_STATUS, 32'h0000_0000);

        // glitch
        @(posedge clk); #1; rxd = 1'b0;
        repeat (3) @(posedge clk); #1; rxd = 1'b1;
        repeat (30) @(posedge clk);
        rd_l(A_STATUS, 32'h0000_0000);

        // break: one frame error, nothing after it is cleared
        @(posedge clk); #1; rxd = 1'b0;
        repeat (150) @(posedge clk);
        m_ferr = 1'b1;
        rd_l(A_STATUS, 32'h0000_0008);
        wr_reg(A_STATUS, 32'h8);
        repeat (150) @(posedge clk); #1; rxd = 1'b1;
        repeat (20) @(posedge clk);
        rd_l(A_STATUS, 32'h0000_0000);

        // full FIFO, pop acked on the push cycle
        for (int i = 0; i < 16; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        rd_l(A_STATUS, 32'h0000_1003);
        fork
            send_frame(8'hEE, 1'b1);
            begin
                @(posedge clk);
                repeat (96) @(posedge clk);
                rd_m(A_RXDATA);
            end
        join
        rd_l(A_STATUS, 32'h0000_1003);
        for (int i = 0; i < 15; i++) rd_m(A_RXDATA);
        rd_l(A_RXDATA, 32'h0000_00EE);
        rd_l(A_STATUS, 32'h0000_0000);

        // back-to-back strobes
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        b2b(1'b1);
        b2b(1'b0);
        rd_l(A_STATUS, 32'h0000_0000);

        // reset mid data bit flushes FIFO
        send_frame(8'h77, 1'b1);
        @(posedge clk); #1; rxd = 1'b0;
        repeat (45) @(posedge clk); #1;
        rst = 1'b1; rxd = 1'b1;
        m_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        rd_l(A_STATUS, 32'h0000_0000);
        send_frame(8'h5A, 1'b1);
        rd_l(A_RXDATA, 32'h0000_005A);

        // empty read, reserved and unselected addresses
        rd_l(A_RXDATA, 32'h0000_0000);
        rd_l(A_STATUS, 32'h0000_0000);
        send_frame(8'hC3, 1'b1);
        rd_m(A_OUT);
        bus(A_OUT, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0);
        wr_reg(A_RXDATA, 32'hFF);
        rd_l(A_RSV8, 32'h0000_0000);
        wr_reg(A_RSV8, 32'hFFFF_FFFF);
        rd_l(A_STATUS, 32'h0000_0101);
        rd_m(A_RXDATA);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) begin
                nrd = $urandom_range(1, 3);
                for (int k = 0; k < nrd; k++) rd_m(A_RXDATA);
            end
            if ($urandom_range(0, 3) == 0) rd_m(A_STATUS);
            chk_irq("irq_random");
        end
        rd_m(A_STATUS);
        while (m_q.size() > 0) rd_m(A_RXDATA);
        wr_reg(A_STATUS, 32'hC);
        rd_l(A_STATUS, 32'h0000_0000);
        chk_irq("irq_end");

        repeat (5) @(posedge clk);
        if (due_q.size() != 0) begin
            n_checks++;
            $display("FAIL pending_acks: got %0d outstanding, required 0", due_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcs_uart_rx.md
# mcs_uart_rx

UART receiver with a receive FIFO, exposed as a responder on the MicroBlaze MCS I/O bus. It is the receive counterpart of the MCS `UART_Tx` line and sits beside MYPIO on the same `IO_*` bus. Firmware polls or takes an interrupt, then reads received bytes by address.

## Interface
- `CLK_HZ`, default 50_000_000: `CLK` frequency.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD`, truncated; 434 at the defaults.
- `DEPTH`, default 16: FIFO entries, power of 2.
- `BASE_ADDR`, default 32'hC000_0010: 16-byte-aligned register window.

Ports. The block has one clock; reset is synchronous and active-high.
- `CLK` in 1: system clock, 50 MHz.
- `RST` in 1: synchronous, active-high reset.
- `RXD` in 1: serial input, asynchronous, idle high.
- `IO_Address` in 32: MCS I/O address.
- `IO_Addr_Strobe` in 1: transaction valid, one cycle.
- `IO_Read_Strobe` in 1: read qualifier.
- `IO_Write_Strobe` in 1: write qualifier.
- `IO_Byte_Enable` in 4: write byte lanes.
- `IO_Write_Data` in 32: write data.
- `IO_Read_Data` out 32: read data. It is zero outside this block's ack cycle, so the top level can OR it with other responders.
- `IO_Ready` out 1: one-cycle acknowledge.
- `RX_IRQ` out 1: high while the FIFO is not empty.

## Operation
- **Selection:** `sel = IO_Addr_Strobe & (IO_Address[31:4] == BASE_ADDR[31:4])`. Register offset is `IO_Address[3:2]`.
- **Register map:**
  - 0x0 RXDATA: read returns `{24'b0, head}` and pops. A read when empty returns 0 and does not pop. Writes are acked and ignored.
  - 0x4 STATUS: bit0 VALID (not empty), bit1 FULL, bit2 OVERRUN, bit3 FRAME_ERR, bits[12:8] COUNT (0..DEPTH), all other bits 0. A write with `IO_Byte_Enable[0]=1` clears bit2 and/or bit3 where `IO_Write_Data` has a 1 (write-1-to-clear).
  - 0x8 and 0xC: read 0, writes ignored, always acked.
- **Input path:** `RXD` passes through a 2-FF synchronizer, then an edge register. Bit-time counter runs 0..`CLKS_PER_BIT-1`.
- **State machine:**
  - IDLE: on a falling edge of synchronized `RXD` → START, counter cleared.
  - START: at `CLKS_PER_BIT/2` sample the line. Low → DATA. High → IDLE (glitch rejected).
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, 8 bits → STOP.
  - STOP: sample one bit later. High → push the byte. Low → set FRAME_ERR, discard the byte. Either way → IDLE.
  - IDLE only re-arms on a falling edge, so a held-low break produces one frame error, not a stream of errors.
- **Push when full:** byte dropped, OVERRUN set, FIFO contents unchanged.
- **Push and pop in the same cycle:** both take effect and COUNT is unchanged. This includes the full case: the push is accepted and OVERRUN is not set.
- **Sticky flags:** OVERRUN and FRAME_ERR stay set until cleared by W1C. If a W1C clear and a new error event land in the same cycle, the set wins.

## Timing
- **Reset values:** `IO_Ready`=0, `IO_Read_Data`=0, `RX_IRQ`=0, FIFO empty, flags 0, FSM in IDLE. Synchronizer flops reset to 1.
- **Reset mid-frame:** the frame is aborted, no push, FIFO flushed.
- **Bus latency:** `sel` in cycle N → `IO_Ready`=1 and `IO_Read_Data` valid in cycle N+1 only, for both reads and writes.
  - The pop and any W1C take effect at the N+1 clock edge.
  - STATUS read in cycle N+1 reflects state at cycle N.
  - Back-to-back strobes in N and N+1 are both served, with acks in N+1 and N+2.
- **Unselected addresses:** no ack and no side effects.
- **RX latency:** the push occurs at the STOP mid-bit sample. COUNT, VALID and `RX_IRQ` update the following cycle. Start detection adds 3 cycles of synchronizer/edge delay.

## Structure
- Shared package `mcs_io_pkg`:
  - register offsets `RXDATA_OFS`, `STATUS_OFS`
  - STATUS bit indices
  - FSM state encoding `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`
- One sub-module, `uart_rx_fifo`:
  - synchronous FIFO, parameterized by `DEPTH` and width 8
  - ports: `push`, `pop`, `din`, `dout` (head, first-word fall-through), `count`, `full`, `empty`
  - simultaneous push and pop when full is legal
- The top of the block contains the synchronizer, FSM, bus decode and flags.

## Test plan
All scenarios use `CLK_HZ`=1_000_000 and `BAUD`=100_000, giving 10 clocks per bit.
- **Single byte:** send 8'hA5 with a valid stop bit → COUNT=1 and `RX_IRQ`=1 the cycle after the stop sample. RXDATA read → `IO_Ready` next cycle with data 32'h0000_00A5; COUNT=0 and `RX_IRQ`=0 afterwards.
- **Overrun:** send 17 bytes 8'h00..8'h10 without reading → STATUS = FULL|VALID|OVERRUN with COUNT=16. Sixteen reads return 00..0F in order; byte 8'h10 is lost.
- **Frame error:** send 8'h3C with stop bit 0 → FRAME_ERR=1 and COUNT=0. Write STATUS with 32'h8 → STATUS reads 0.
- **Glitch and break:** a 3-cycle low pulse on `RXD` → no push, no error. `RXD` held low for 30 bit times → exactly one FRAME_ERR and no push.
- **Simultaneous push/pop:** FIFO full and an RXDATA read acked on the same cycle as a push → COUNT stays 16 and OVERRUN stays 0.
- **Reset and empty read:** `RST` asserted mid-data-bit, then a fresh 8'h5A is received correctly. A read of an empty FIFO returns 0 with COUNT unchanged. An access to `BASE_ADDR`+0x20 gets no `IO_Ready`.
